pc_sequencer: RTL and testbench

Fetch/PC sequencing controller for the single-issue RISC-V core. It owns the program counter and fetches one instruction at a time over a request/acknowledge instruction-memory handshake. It presents each fetched instruction to the decode block and datapath, then updates the PC from decode's `next_pc_sel`. Misaligned targets and fetch timeouts put it in a sticky trap state.

---
 rtl/pc_sequencer_if.sv | 21 ++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - instruction-memory request/acknowledge bundle for pc_sequencer
interface pc_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - single-issue fetch/PC sequencer with sticky trap
module pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [15:0] FETCH_TIMEOUT = 16'd255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        imem,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    input  logic [2:0]            next_pc_sel,
    input  logic [31:0]           jal_imm,
    input  logic [31:0]           brch_imm,
    input  logic [31:0]           i_imm,
    input  logic [31:0]           rf_rs1,
    input  logic                  brch_taken,
    input  logic                  stall,
    output logic [31:0]           pc,
    output logic                  retire,
    output logic                  trap,
    output logic [1:0]            trap_cause
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_TRAP
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [15:0] wait_q, wait_d;
    logic        retire_q, retire_d;
    logic        trap_q, trap_d;
    logic [1:0]  cause_q, cause_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [15:0] wait_inc;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        case (next_pc_sel)
            3'd1:    target = pc_q + jal_imm;
            3'd2:    target = brch_taken ? (pc_q + brch_imm) : pc_plus4;
            3'd3:    target = (rf_rs1 + i_imm) & 32'hFFFF_FFFE;
            default: target = pc_plus4;
        endcase
    end

    assign wait_inc = wait_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= NOP;
            wait_q   <= 16'd0;
            retire_q <= 1'b0;
            trap_q   <= 1'b0;
            cause_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
            trap_q   <= trap_d;
            cause_q  <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        wait_d   = wait_q;
        retire_d = 1'b0;
        trap_d   = trap_q;
        cause_d  = cause_q;

        case (state_q)
            S_IDLE: begin
                wait_d  = 16'd0;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack in the timeout cycle still wins: the check sits in the no-ack branch.
                if (imem.imem_ack) begin
                    inst_d  = imem.imem_rdata;
                    wait_d  = 16'd0;
                    state_d = S_EXEC;
                end else begin
                    wait_d = wait_inc;
                    if ((FETCH_TIMEOUT != 16'd0) && (wait_inc == FETCH_TIMEOUT)) begin
                        wait_d  = 16'd0;
                        trap_d  = 1'b1;
                        cause_d = 2'd1;
                        state_d = S_TRAP;
                    end
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (target[1:0] != 2'b00) begin
                        trap_d  = 1'b1;
                        cause_d = 2'd2;
                        state_d = S_TRAP;
                    end else begin
                        pc_d     = target;
                        retire_d = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign inst           = inst_q;
    assign inst_valid     = (state_q == S_EXEC);
    assign pc             = pc_q;
    assign retire         = retire_q;
    assign trap           = trap_q;
    assign trap_cause     = cause_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - transaction-level model bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  next_pc_sel;
    logic [31:0] jal_imm, brch_imm, i_imm, rf_rs1;
    logic        brch_taken, stall;
    logic        ack;
    logic [31:0] rdata;

    pc_sequencer_if if_m();
    pc_sequencer_if if_t();
    assign if_m.imem_ack   = ack;
    assign if_m.imem_rdata = rdata;
    assign if_t.imem_ack   = ack;
    assign if_t.imem_rdata = rdata;

    logic [31:0] inst_m, pc_m, inst_t, pc_t;
    logic        valid_m, retire_m, trap_m, valid_t, retire_t, trap_t;
    logic [1:0]  cause_m, cause_t;

    pc_sequencer #(.RESET_PC(RPC)) dut_m (
        .clk(clk), .rst_n(rst_n), .imem(if_m.master),
        .inst(inst_m), .inst_valid(valid_m), .next_pc_sel(next_pc_sel),
        .jal_imm(jal_imm), .brch_imm(brch_imm), .i_imm(i_imm), .rf_rs1(rf_rs1),
        .brch_taken(brch_taken), .stall(stall), .pc(pc_m), .retire(retire_m),
        .trap(trap_m), .trap_cause(cause_m)
    );

    pc_sequencer #(.RESET_PC(RPC), .FETCH_TIMEOUT(16'd4)) dut_t (
        .clk(clk), .rst_n(rst_n), .imem(if_t.master),
        .inst(inst_t), .inst_valid(valid_t), .next_pc_sel(next_pc_sel),
        .jal_imm(jal_imm), .brch_imm(brch_imm), .i_imm(i_imm), .rf_rs1(rf_rs1),
        .brch_taken(brch_taken), .stall(stall), .pc(pc_t), .retire(retire_t),
        .trap(trap_t), .trap_cause(cause_t)
    );

    logic use_t;
    wire        o_req    = use_t ? if_t.imem_req  : if_m.imem_req;
    wire [31:0] o_addr   = use_t ? if_t.imem_addr : if_m.imem_addr;
    wire [31:0] o_inst   = use_t ? inst_t   : inst_m;
    wire        o_valid  = use_t ? valid_t  : valid_m;
    wire [31:0] o_pc     = use_t ? pc_t     : pc_m;
    wire        o_retire = use_t ? retire_t : retire_m;
    wire        o_trap   = use_t ? trap_t   : trap_m;
    wire [1:0]  o_cause  = use_t ? cause_t  : cause_m;

    // Architectural model state: advanced once per instruction, not per cycle.
    logic [31:0] m_pc, m_inst;
    logic        m_ret, m_trap;
    logic [1:0]  m_cause;

    logic        chk_en;
    logic        e_req, e_valid, e_retire, e_trap;
    logic [31:0] e_pc, e_inst;
    logic [1:0]  e_cause;

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req",   {31'd0, o_req},    {31'd0, e_req});
            chk("imem_addr",  o_addr,            e_pc);
            chk("pc",         o_pc,              e_pc);
            chk("inst",       o_inst,            e_inst);
            chk("inst_valid", {31'd0, o_valid},  {31'd0, e_valid});
            chk("retire",     {31'd0, o_retire}, {31'd0, e_retire});
            chk("trap",       {31'd0, o_trap},   {31'd0, e_trap});
            chk("trap_cause", {30'd0, o_cause},  {30'd0, e_cause});
        end
    end

    function automatic logic [31:0] next_target(input logic [2:0] sel, input logic [31:0] cur,
                                                 input logic [31:0] a, input logic [31:0] b,
                                                 input logic taken);
        case (sel)
            3'd1:    return cur + a;
            3'd2:    return taken ? cur + a : cur + 32'd4;
            3'd3:    return (a + b) & ~32'd1;
            default: return cur + 32'd4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic req, input logic valid, input logic ret);
        e_req    = req;
        e_valid  = valid;
        e_retire = ret;
        e_pc     = m_pc;
        e_inst   = m_inst;
        e_trap   = m_trap;
        e_cause  = m_cause;
        chk_en   = 1'b1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ack    = 1'b0;
        stall  = 1'b0;
        chk_en = 1'b0;
        step();
        rst_n   = 1'b1;
        m_pc    = RPC;
        m_inst  = 32'h0000_0013;
        m_ret   = 1'b0;
        m_trap  = 1'b0;
        m_cause = 2'd0;
        set_exp(1'b0, 1'b0, 1'b0);
    endtask

    task automatic fetch_no_ack(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            ack   = 1'b0;
            rdata = $urandom;
            set_exp(1'b1, 1'b0, (k == 0) ? m_ret : 1'b0);
        end
        m_ret = 1'b0;
    endtask

    task automatic trap_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            ack   = (k % 2 == 0);
            rdata = $urandom;
            stall = 1'b0;
            set_exp(1'b0, 1'b0, 1'b0);
        end
    endtask

    // a: jal_imm / brch_imm / rf_rs1 depending on sel; b: i_imm for sel 3.
    task automatic do_instr(input int dly, input int stalls, input logic [2:0] sel,
                            input logic [31:0] a, input logic [31:0] b, input logic taken);
        logic [31:0] word;
        logic [31:0] t;
        word = $urandom;
        for (int k = 0; k <= dly; k++) begin
            step();
            ack   = (k == dly);
            rdata = (k == dly) ? word : ~word;
            stall = 1'b0;
            set_exp(1'b1, 1'b0, (k == 0) ? m_ret : 1'b0);
        end
        m_ret  = 1'b0;
        m_inst = word;
        for (int k = 0; k <= stalls; k++) begin
            step();
            ack         = 1'b1;
            rdata       = $urandom;
            stall       = (k < stalls);
            next_pc_sel = sel;
            jal_imm     = (sel == 3'd1) ? a : $urandom;
            brch_imm    = (sel == 3'd2) ? a : $urandom;
            rf_rs1      = (sel == 3'd3) ? a : $urandom;
            i_imm       = (sel == 3'd3) ? b : $urandom;
            brch_taken  = taken;
            set_exp(1'b0, 1'b1, 1'b0);
        end
        t = next_target(sel, m_pc, a, b, taken);
        if (t[1:0] != 2'b00) begin
            m_trap  = 1'b1;
            m_cause = 2'd2;
        end else begin
            m_pc  = t;
            m_ret = 1'b1;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ack = 1'b0;
        rdata = '0;
        stall = 1'b0;
        next_pc_sel = 3'd0;
        jal_imm = '0;
        brch_imm = '0;
        i_imm = '0;
        rf_rs1 = '0;
        brch_taken = 1'b0;
        use_t = 1'b0;
        chk_en = 1'b0;

        do_reset();
        do_instr(0, 0, 3'd0, 32'd0, 32'd0, 1'b0);
        do_instr(0, 0, 3'd0, 32'd0, 32'd0, 1'b0);
        do_instr(0, 0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("pin_seq", m_pc, 32'h0000_010C);
        do_instr(0, 0, 3'd1, 32'h0000_00F4, 32'd0, 1'b0);
        chk("pin_jal_fwd", m_pc, 32'h0000_0200);
        do_instr(0, 0, 3'd1, 32'hFFFF_FFF0, 32'd0, 1'b0);
        chk("pin_jal_back", m_pc, 32'h0000_01F0);
        do_instr(1, 0, 3'd2, 32'h0000_0040, 32'd0, 1'b1);
        chk("pin_brch_taken", m_pc, 32'h0000_0230);
        do_instr(0, 0, 3'd3, 32'h0000_01F0, 32'd0, 1'b0);
        do_instr(0, 1, 3'd2, 32'h0000_0040, 32'd0, 1'b0);
        chk("pin_brch_untaken", m_pc, 32'h0000_01F4);
        do_instr(0, 0, 3'd3, 32'h0000_1001, 32'h0000_0004, 1'b0);
        chk("pin_jalr", m_pc, 32'h0000_1004);
        do_instr(5, 0, 3'd0, 32'd0, 32'd0, 1'b0);
        do_instr(0, 3, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("pin_stall", m_pc, 32'h0000_100C);
        do_instr(2, 0, 3'd3, 32'hFFFF_FFF8, 32'h0000_0004, 1'b0);
        do_instr(0, 0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("pin_wrap", m_pc, 32'h0000_0000);
        do_instr(0, 0, 3'd5, 32'd0, 32'd0, 1'b0);
        do_instr(0, 0, 3'd2, 32'h0000_0002, 32'd0, 1'b0);
        chk("pin_sel_hi", m_pc, 32'h0000_0008);
        do_instr(0, 2, 3'd3, 32'h0000_1002, 32'd0, 1'b0);
        chk("pin_misalign_pc", m_pc, 32'h0000_0008);
        trap_cycles(4);

        do_reset();
        fetch_no_ack(3);
        do_reset();
        do_instr(0, 0, 3'd0, 32'd0, 32'd0, 1'b0);
        fetch_no_ack(1);

        use_t = 1'b1;
        do_reset();
        do_instr(3, 0, 3'd0, 32'd0, 32'd0, 1'b0);
        fetch_no_ack(4);
        m_trap  = 1'b1;
        m_cause = 2'd1;
        trap_cycles(3);
        do_reset();
        do_instr(1, 0, 3'd1, 32'h0000_0010, 32'd0, 1'b0);
        fetch_no_ack(1);
        chk("pin_recover", m_pc, 32'h0000_0110);

        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
